// File: rtl/stream_resizer_pkg.sv
// -----------------------------------------------------------------------------
// stream_resizer_pkg
// Shared types and helpers for the stream lane-width converter.
//   lane_tag_t      : per-entry flags stored next to each buffered lane
//   FILL_W / PTR_W  : fill-count and pointer widths of the reference
//                     8-entry lane buffer
//   popcount        : number of set bits in a keep-style vector
//   first_last_idx  : lowest set index among the first 'lanes' bits, or -1
// -----------------------------------------------------------------------------
package stream_resizer_pkg;

  localparam int BUF_LANES_DFLT = 8;
  localparam int FILL_W         = $clog2(BUF_LANES_DFLT + 1);
  localparam int PTR_W          = $clog2(BUF_LANES_DFLT);

  // Widest keep/flag vector the helper functions operate on.
  localparam int VEC_W = 32;

  // Flags carried by every buffered lane. A null entry terminates a packet
  // that has no data lane of its own, so it always has last set as well.
  typedef struct packed {
    logic last;
    logic is_null;
  } lane_tag_t;

  function automatic int popcount(input logic [VEC_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < VEC_W; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

  // Scanning downward leaves the lowest matching index in idx.
  function automatic int first_last_idx(input logic [VEC_W-1:0] flags,
                                        input int lanes);
    int idx;
    idx = -1;
    for (int i = VEC_W - 1; i >= 0; i--) begin
      if ((i < lanes) && flags[i]) begin
        idx = i;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/lane_compactor.sv
// -----------------------------------------------------------------------------
// lane_compactor
// Combinational packing of a sparse input beat into a dense lane vector.
//   i_keep  : per-lane valid of the input beat
//   i_last  : input beat ends its packet
//   i_data  : input lanes
//   o_data  : kept lanes packed from index 0 upward, unused slots zero
//   o_cnt   : number of entries to append (1 for a null terminator)
//   o_null  : beat carries no lanes but closes a packet
// -----------------------------------------------------------------------------
module lane_compactor
  import stream_resizer_pkg::*;
#(
  parameter int S_KEEP_WIDTH = 3,
  parameter int T_DATA_WIDTH = 4,
  localparam int CW = $clog2(S_KEEP_WIDTH + 1)
) (
  input  logic [S_KEEP_WIDTH-1:0] i_keep,
  input  logic                    i_last,
  input  logic [T_DATA_WIDTH-1:0] i_data [S_KEEP_WIDTH],
  output logic [T_DATA_WIDTH-1:0] o_data [S_KEEP_WIDTH],
  output logic [CW-1:0]           o_cnt,
  output logic                    o_null
);

  localparam int IW = (S_KEEP_WIDTH > 1) ? $clog2(S_KEEP_WIDTH) : 1;

  logic [IW-1:0] w_pos;

  always_comb begin
    o_data = '{default: '0};
    w_pos  = '0;
    for (int i = 0; i < S_KEEP_WIDTH; i++) begin
      if (i_keep[i]) begin
        o_data[w_pos] = i_data[i];
        w_pos         = w_pos + 1'b1;
      end
    end
    o_null = (i_keep == '0) && i_last;
    o_cnt  = o_null ? CW'(1) : CW'(popcount(VEC_W'(i_keep)));
  end

endmodule

// File: rtl/stream_resizer_gen.sv
// -----------------------------------------------------------------------------
// stream_resizer_gen
// Valid/ready lane-width converter: S_KEEP_WIDTH input lanes to M_KEEP_WIDTH
// output lanes through a circular lane buffer of BUF_LANES entries. Sparse
// input keep is compacted; an all-zero keep with last appends a null
// terminator entry.
//   clk, rst_n            : clock, asynchronous active-low reset
//   s_valid_i/s_ready_o   : input handshake (s_ready_o is registered)
//   s_last_i/s_keep_i/s_data_i : input beat
//   m_valid_o/m_ready_i   : output handshake
//   m_last_o/m_keep_o/m_data_o : output beat, first-word-fall-through
//   fill_o                : number of buffered entries
// -----------------------------------------------------------------------------
module stream_resizer_gen
  import stream_resizer_pkg::*;
#(
  parameter int S_KEEP_WIDTH = 3,
  parameter int M_KEEP_WIDTH = 2,
  parameter int T_DATA_WIDTH = 4,
  parameter int BUF_LANES    = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             s_valid_i,
  input  logic                             s_last_i,
  input  logic [S_KEEP_WIDTH-1:0]          s_keep_i,
  input  logic [T_DATA_WIDTH-1:0]          s_data_i [S_KEEP_WIDTH],
  output logic                             s_ready_o,
  output logic                             m_valid_o,
  input  logic                             m_ready_i,
  output logic                             m_last_o,
  output logic [M_KEEP_WIDTH-1:0]          m_keep_o,
  output logic [T_DATA_WIDTH-1:0]          m_data_o [M_KEEP_WIDTH],
  output logic [$clog2(BUF_LANES+1)-1:0]   fill_o
);

  localparam int CW = $clog2(S_KEEP_WIDTH + 1);
  localparam int NW = $clog2(M_KEEP_WIDTH + 1);
  localparam int FW = $clog2(BUF_LANES + 1);
  localparam int PW = $clog2(BUF_LANES);

  if (BUF_LANES < S_KEEP_WIDTH + M_KEEP_WIDTH) begin : g_bad_buf
    $error("stream_resizer_gen: BUF_LANES must be >= S_KEEP_WIDTH + M_KEEP_WIDTH");
  end
  if ((S_KEEP_WIDTH > VEC_W) || (M_KEEP_WIDTH > VEC_W)) begin : g_bad_width
    $error("stream_resizer_gen: keep widths limited to VEC_W lanes");
  end

  typedef struct packed {
    logic [T_DATA_WIDTH-1:0] data;
    lane_tag_t               tag;
  } lane_entry_t;

  lane_entry_t   r_buf [BUF_LANES];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [FW-1:0] r_fill;
  logic          r_s_ready;

  logic [T_DATA_WIDTH-1:0] w_c_data [S_KEEP_WIDTH];
  logic [CW-1:0]           w_c_cnt;
  logic                    w_c_null;

  lane_entry_t             w_ent [M_KEEP_WIDTH];
  logic [M_KEEP_WIDTH-1:0] w_last_mask;
  int                      w_first_last;
  logic [NW-1:0]           w_beat_n;
  logic                    w_m_valid;
  logic                    w_m_last;
  logic                    w_push;
  logic                    w_pop;
  logic [FW-1:0]           w_fill_next;
  logic                    w_s_ready_next;

  // Both offsets stay below BUF_LANES, so one conditional subtract wraps.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= BUF_LANES) begin
      s = s - BUF_LANES;
    end
    return PW'(s);
  endfunction

  lane_compactor #(
    .S_KEEP_WIDTH (S_KEEP_WIDTH),
    .T_DATA_WIDTH (T_DATA_WIDTH)
  ) u_compactor (
    .i_keep (s_keep_i),
    .i_last (s_last_i),
    .i_data (s_data_i),
    .o_data (w_c_data),
    .o_cnt  (w_c_cnt),
    .o_null (w_c_null)
  );

  // Output beat framing: stop after the first last-flagged entry in the
  // head window so two packets never share a beat; otherwise wait for a
  // full window.
  always_comb begin
    w_last_mask = '0;
    for (int j = 0; j < M_KEEP_WIDTH; j++) begin
      w_ent[j]       = r_buf[ptr_add(r_head, j)];
      w_last_mask[j] = (FW'(j) < r_fill) && w_ent[j].tag.last;
    end
    w_first_last = first_last_idx(VEC_W'(w_last_mask), M_KEEP_WIDTH);
    if (w_first_last >= 0) begin
      w_beat_n  = NW'(w_first_last + 1);
      w_m_valid = 1'b1;
      w_m_last  = 1'b1;
    end else begin
      w_beat_n  = NW'(M_KEEP_WIDTH);
      w_m_valid = (r_fill >= FW'(M_KEEP_WIDTH));
      w_m_last  = 1'b0;
    end
    for (int j = 0; j < M_KEEP_WIDTH; j++) begin
      m_keep_o[j] = w_m_valid && (j < int'(w_beat_n)) && !w_ent[j].tag.is_null;
      m_data_o[j] = m_keep_o[j] ? w_ent[j].data : '0;
    end
  end

  assign m_valid_o = w_m_valid;
  assign m_last_o  = w_m_last;
  assign s_ready_o = r_s_ready;
  assign fill_o    = r_fill;

  assign w_push = s_valid_i && r_s_ready;
  assign w_pop  = w_m_valid && m_ready_i;

  always_comb begin
    w_fill_next = r_fill;
    if (w_push) begin
      w_fill_next = w_fill_next + FW'(w_c_cnt);
    end
    if (w_pop) begin
      w_fill_next = w_fill_next - FW'(w_beat_n);
    end
    // Ready only promises room for a worst-case full-keep beat.
    w_s_ready_next = (FW'(BUF_LANES) - w_fill_next) >= FW'(S_KEEP_WIDTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_fill    <= '0;
      r_s_ready <= 1'b0;
    end else begin
      if (w_pop) begin
        r_head <= ptr_add(r_head, int'(w_beat_n));
      end
      if (w_push) begin
        r_tail <= ptr_add(r_tail, int'(w_c_cnt));
      end
      r_fill    <= w_fill_next;
      r_s_ready <= w_s_ready_next;
    end
  end

  // Lane storage is not reset; fill and pointers decide what is live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int k = 0; k < S_KEEP_WIDTH; k++) begin
        if (k < int'(w_c_cnt)) begin
          r_buf[ptr_add(r_tail, k)].data        <= w_c_null ? '0 : w_c_data[k];
          r_buf[ptr_add(r_tail, k)].tag.last    <= s_last_i && (k == int'(w_c_cnt) - 1);
          r_buf[ptr_add(r_tail, k)].tag.is_null <= w_c_null;
        end
      end
    end
  end

endmodule

// File: doc/stream_resizer_gen.md
Name: stream_resizer_gen

Overview:
Parametrised AXI-Stream-style lane-width converter: S_KEEP_WIDTH input lanes to M_KEEP_WIDTH output lanes of T_DATA_WIDTH bits each. Successor to the fixed resizer, adding three features: sparse-keep compaction, a configurable lane buffer, and zero-keep (null) packet terminators. It sits between stream producers and consumers whose bus widths differ, with full valid/ready backpressure on both sides.

Parameters:
S_KEEP_WIDTH, 3, input lanes per beat
M_KEEP_WIDTH, 2, output lanes per beat
T_DATA_WIDTH, 4, bits per lane
BUF_LANES, 8, lane buffer depth in entries; elaboration error if < S_KEEP_WIDTH + M_KEEP_WIDTH

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
s_valid_i  in  1  input beat valid
s_last_i  in  1  input beat ends the packet
s_keep_i  in  S_KEEP_WIDTH  per-lane valid; may be sparse
s_data_i  in  T_DATA_WIDTH x S_KEEP_WIDTH (unpacked array)  input lanes
s_ready_o  out  1  beat accepted when s_valid_i && s_ready_o
m_valid_o  out  1  output beat valid
m_ready_i  in  1  consumer ready
m_last_o  out  1  output beat ends the packet
m_keep_o  out  M_KEEP_WIDTH  per-lane valid
m_data_o  out  T_DATA_WIDTH x M_KEEP_WIDTH (unpacked array)  output lanes
fill_o  out  $clog2(BUF_LANES+1)  buffered entry count

Behaviour:
- Reset (rst_n low, takes effect immediately): buffer emptied, fill_o=0, s_ready_o=0, m_valid_o=0, m_last_o=0, m_keep_o=0, m_data_o all 0. All in-flight data is discarded. Normal operation starts on the first edge after release.
- Buffer entry fields: {data, last, null}. Circular FIFO with head/tail pointers wrapping modulo BUF_LANES.
- Accept:
  - Kept lanes are compacted in ascending lane order (lane 0 first) and appended.
  - If s_last_i=1, the final appended entry has last=1.
  - keep=0, last=0: beat accepted and discarded.
  - keep=0, last=1: one entry appended with null=1, last=1.
- s_ready_o is registered. It is 1 iff (BUF_LANES - fill_next) >= S_KEEP_WIDTH. It has no combinational path from m_ready_i or s_valid_i.
- Output (first-word-fall-through from head):
  - n = number of entries up to and including the first last-flagged entry among the first M_KEEP_WIDTH entries.
  - If a last-flagged entry is found within those entries, the beat holds n entries and m_last_o=1.
  - Otherwise the beat holds M_KEEP_WIDTH entries, and m_valid_o is asserted only when fill >= M_KEEP_WIDTH.
  - Partial beats exist only at packet end.
- m_keep_o: contiguous low ones, one per non-null entry in the beat. A null entry contributes a 0 keep bit and is always the final entry of its beat.
- m_data_o: lanes with m_keep_o=0 are driven to 0.
- Pop: on m_valid_o && m_ready_i the head advances by the beat size.
- Simultaneous push and pop in one cycle: fill_next = fill + pushed - popped.
- Latency: a lane accepted at edge k is visible on m_data_o after edge k (combinational from state). Minimum latency is 1 cycle.
- Holding rule: while m_valid_o=1 and m_ready_i=0, all m_* outputs stay stable.
- Multiple packets may be buffered at once. Packet boundaries are never merged into one output beat.

Decomposition:
- Package stream_resizer_pkg holds:
  - lane entry struct typedef;
  - FILL_W and PTR_W localparams;
  - popcount function;
  - first-last-index search function.
- Sub-module lane_compactor is combinational. It maps s_keep_i/s_data_i to a dense lane vector plus a count, and handles the null-entry case. It is instantiated once.

Test Plan (S=3, M=2, T=4, BUF_LANES=8):
1. Full-keep packet: keep=111, data {1,0,1}, last=1, m_ready_i=1 -> beat {1,0} keep=11 last=0; then beat {1,0} keep=01 last=1.
2. Sparse keep: beat keep=101, data {6,7,8}, last=0; then beat keep=010, data {9,10,11}, last=1 -> beat {6,8} keep=11 last=0; beat {10,0} keep=01 last=1.
3. Sustained input: four back-to-back full beats (data 1..12), last on the 4th, m_ready_i=1 -> s_ready_o drops whenever fill > 5; all 12 lanes emitted in order; final beat last=1; no lane lost or duplicated.
4. Output stall: m_ready_i=0 while 9 lanes are offered -> fill_o saturates at 6, s_ready_o=0, m_* stable; releasing m_ready_i drains all lanes correctly.
5. Null packet: keep=000, last=1 -> one beat, m_keep_o=00, m_last_o=1. A null packet following lanes {5} of an open packet -> beat {5,0} keep=01 last=1.
6. Mid-packet reset: assert rst_n low after 2 of 4 beats -> outputs and fill_o go 0 asynchronously. The next packet after release (keep=111, data {4,5,6}, last=1) is emitted correctly: beat {4,5} keep=11 last=0, then beat {6,0} keep=01 last=1.
